// File: rtl/iter_addsub_ctrl.sv
// Bit-serial adder/subtractor: captures one operand pair, resolves one bit per cycle
// LSB-first through a registered ripple carry, then holds the result until it is taken.
module iter_addsub_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic [WIDTH-2:0] sum_sr;

  logic             accept;
  logic             last_bit;
  logic             bit_a, bit_b;
  logic             sum_bit, carry_nxt;
  logic [WIDTH-1:0] sum_next;

  // Flush wins over a coincident request, so it also vetoes acceptance.
  assign accept    = in_valid & in_ready & ~flush;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  assign bit_a     = a_q[cnt];
  assign bit_b     = b_q[cnt] ^ sub_q;
  assign sum_bit   = bit_a ^ bit_b ^ carry;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);
  assign sum_next  = {sum_bit, sum_sr};

  // Gated by the reset input so the block never advertises readiness while held in reset.
  assign in_ready  = (state == IDLE) & aclr_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaulting every combinational output first keeps the tool from inferring a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      sum_sr <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (flush) begin
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      sub_q  <= sub;
      cnt    <= '0;
      carry  <= sub;
    end else if (state == RUN) begin
      // Shift in from the top so bit i settles at position i after WIDTH steps.
      sum_sr <= sum_next[WIDTH-1:1];
      carry  <= carry_nxt;
      cnt    <= cnt + 1'b1;
      if (last_bit) begin
        result <= sum_next;
        cout   <= carry_nxt;
        ovf    <= carry ^ carry_nxt;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_iter_addsub_ctrl.sv
// Directed bench for iter_addsub_ctrl at WIDTH=8 with a queue scoreboard of expected results.
module tb_iter_addsub_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         aclr_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int           checks = 0;
  int           failures = 0;
  exp_t         sb[$];
  logic [W-1:0] last_res = '0;

  iter_addsub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish in time");
  end

  // Whole-word reference: a + (b or ~b) + sub, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         m;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    m.res = full[W-1:0];
    m.c   = full[W];
    m.o   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    sb.push_back(model(ta, tb_, ts));
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (out_valid !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check("accept_to_out_valid_edges", 64'(n), 64'(W));
  endtask

  task automatic drain(input int hold);
    exp_t e;
    check("scoreboard_depth", 64'(sb.size()), 64'd1);
    e = sb.pop_front();
    check("result", {56'd0, result}, {56'd0, e.res});
    check("cout", {63'd0, cout}, {63'd0, e.c});
    check("ovf", {63'd0, ovf}, {63'd0, e.o});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      @(negedge clk);
      check("hold_result", {56'd0, result}, {56'd0, e.res});
      check("hold_flags", {62'd0, cout, ovf}, {62'd0, e.c, e.o});
      check("hold_out_valid", {62'd0, out_valid, in_ready}, 64'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_take", {62'd0, out_valid, in_ready}, 64'b01);
    last_res = e.res;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
    issue(ta, tb_, ts);
    wait_done();
    drain(0);
  endtask

  initial begin
    logic seen;
    exp_t dropped;

    #3;
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_outputs", {52'd0, out_valid, busy, cout, ovf, result}, 64'd0);
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

    run_op(8'h35, 8'h4A, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'h10, 8'h20, 1'b1);

    // Consumer stalls in DONE while new requests keep arriving.
    issue(8'h80, 8'h01, 1'b1);
    wait_done();
    drain(5);
    run_op(8'h5A, 8'h00, 1'b1);

    // Abort during bit 3 of an operation.
    issue(8'h11, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_state", {61'd0, in_ready, busy, out_valid}, 64'b100);
    check("flush_result_kept", {56'd0, result}, {56'd0, last_res});
    dropped = sb.pop_back();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("no_out_valid_after_flush", {63'd0, seen}, 64'd0);

    // Flush coinciding with a request in IDLE must not accept it.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; a = 8'h01; b = 8'h02; sub = 1'b0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_blocks_accept", {62'd0, busy, in_ready}, 64'b01);

    run_op(8'h90, 8'h90, 1'b0);

    // Asynchronous reset between clock edges in the middle of RUN.
    issue(8'h44, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    aclr_n = 1'b0;
    #1;
    check("async_reset_result", {56'd0, result}, 64'd0);
    check("async_reset_ctrl", {59'd0, in_ready, busy, out_valid, cout, ovf}, 64'd0);
    dropped = sb.pop_back();
    @(negedge clk);
    aclr_n = 1'b1;
    #1;
    check("in_ready_after_rerelease", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("no_out_valid_after_reset", {63'd0, seen}, 64'd0);
    run_op(8'h01, 8'h01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
